// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Multi-cycle instruction sequencer for the register-file ALU datapath.
//   Owns the program counter, fetches from a synchronous instruction memory
//   (data valid the cycle after the address), hands ALU opcodes 0-11 to the
//   datapath over valid/ready and resolves branches/jumps itself using the
//   combinational register-file read ports.
//
//   Build option: define SEQ_JAL_EN to enable jr (21) and jal (22); without
//   it both opcodes take the illegal path and link_we stays low.
//
//   Ports
//     clk, reset        clock, synchronous active-high reset
//     start             begin at START_PC (IDLE/HALTED only)
//     imem_addr/rdata   instruction fetch address / returned word
//     exe_instr/valid   instruction offered to the datapath
//     exe_ready         datapath accepts exe_instr
//     rd_addr_a/b       register read addresses (ir[25:21], ir[20:16])
//     rd_data_a/b       register read data
//     link_we/addr/data jal link write (r31 <= pc+1)
//     pc                program counter
//     busy, halted      status
//     illegal           sticky: an unsupported opcode was skipped
//     retired           saturating count of completed instructions
//
//   state  | meaning
//   IDLE   | out of reset, waiting for start
//   FETCH  | imem_addr = pc presented to memory
//   DECODE | memory word captured into ir
//   EXEC   | execute ir; ALU ops wait here for exe_ready
//   HALTED | halt retired, waiting for start
module instr_sequencer #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     exe_instr,
    output logic            exe_valid,
    input  logic            exe_ready,
    output logic [4:0]      rd_addr_a,
    output logic [4:0]      rd_addr_b,
    input  logic [31:0]     rd_data_a,
    input  logic [31:0]     rd_data_b,
    output logic            link_we,
    output logic [4:0]      link_addr,
    output logic [31:0]     link_data,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [31:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t          state, state_n;
    logic [31:0]     ir, ir_n;
    logic [PC_W-1:0] pc_n, pc_inc, br_off, br_target;
    logic            exe_valid_n, illegal_n, retire, br_taken;
    logic [5:0]      opcode;

    assign opcode    = ir[31:26];
    assign rd_addr_a = ir[25:21];
    assign rd_addr_b = ir[20:16];
    assign pc_inc    = pc + PC_W'(1);
    // sign-extend the 16-bit offset first, then truncate to the pc width
    assign br_off    = PC_W'({{16{ir[15]}}, ir[15:0]});
    assign br_target = pc_inc + br_off;

    assign exe_instr = ir;
    assign imem_addr = (state == S_FETCH) ? pc : '0;
    assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign halted    = (state == S_HALTED);
    assign link_addr = 5'd31;

`ifdef SEQ_JAL_EN
    assign link_we   = (state == S_EXEC) && (opcode == 6'd22);
    assign link_data = link_we ? {{(32-PC_W){1'b0}}, pc_inc} : '0;
`else
    assign link_we   = 1'b0;
    assign link_data = '0;
`endif

    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            6'd14:   br_taken = (rd_data_a == rd_data_b);
            6'd15:   br_taken = (rd_data_a != rd_data_b);
            6'd16:   br_taken = ($signed(rd_data_a) >  $signed(rd_data_b));
            6'd17:   br_taken = ($signed(rd_data_a) >= $signed(rd_data_b));
            6'd18:   br_taken = ($signed(rd_data_a) <  $signed(rd_data_b));
            6'd19:   br_taken = ($signed(rd_data_a) <= $signed(rd_data_b));
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ir_n        = ir;
        exe_valid_n = exe_valid;
        illegal_n   = illegal;
        retire      = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_n   = S_FETCH;
                    pc_n      = START_PC;
                    illegal_n = 1'b0;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                ir_n = imem_rdata;
                // registered valid so it is already high in the first EXEC cycle
                exe_valid_n = (imem_rdata[31:26] <= 6'd11);
                state_n     = S_EXEC;
            end
            S_EXEC: begin
                case (opcode) inside
                    [6'd0:6'd11]: begin
                        if (exe_ready) begin
                            exe_valid_n = 1'b0;
                            pc_n        = pc_inc;
                            retire      = 1'b1;
                            state_n     = S_FETCH;
                        end
                    end
                    [6'd14:6'd19]: begin
                        pc_n    = br_taken ? br_target : pc_inc;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
                    6'd20: begin
                        pc_n    = ir[PC_W-1:0];
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
`ifdef SEQ_JAL_EN
                    6'd21: begin
                        pc_n    = rd_data_a[PC_W-1:0];
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
                    6'd22: begin
                        pc_n    = ir[PC_W-1:0];
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
`endif
                    6'd63: begin
                        retire  = 1'b1;
                        state_n = S_HALTED;
                    end
                    default: begin
                        illegal_n = 1'b1;
                        pc_n      = pc_inc;
                        state_n   = S_FETCH;
                    end
                endcase
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= START_PC;
            ir        <= '0;
            exe_valid <= 1'b0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir        <= ir_n;
            exe_valid <= exe_valid_n;
            illegal   <= illegal_n;
            if (retire && (retired != '1))
                retired <= retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
module tb_instr_sequencer;
    localparam int PC_W    = 9;
    localparam int PC_MASK = (1 << PC_W) - 1;
    localparam logic [PC_W-1:0] START_PC = '0;
    localparam longint RET_MAX = 64'hFFFF_FFFF;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic            clk, reset, start, exe_ready;
    logic [PC_W-1:0] imem_addr, pc;
    logic [31:0]     imem_rdata, exe_instr, rd_data_a, rd_data_b, link_data, retired;
    logic            exe_valid, link_we, busy, halted, illegal;
    logic [4:0]      rd_addr_a, rd_addr_b, link_addr;

    logic [31:0] imem [0:511];
    logic [31:0] regs [0:31];

    int n_cmp = 0;
    int n_bad = 0;

    // instruction-level reference state
    bit          m_known = 0;
    bit          m_run, m_halted, m_ill;
    int          m_cyc, m_pc;
    longint      m_ret;
    logic [31:0] m_word;

    instr_sequencer #(.PC_W(PC_W), .START_PC(START_PC)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .exe_instr(exe_instr), .exe_valid(exe_valid), .exe_ready(exe_ready),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
        .pc(pc), .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem[imem_addr];
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural effect of one instruction word executed at address p.
    task automatic isa_exec(input logic [31:0] w, input int p, output int np,
                            output bit ret, output bit ill, output bit hlt);
        int op, a, b, off;
        bit tk;
        op  = int'(w[31:26]);
        a   = int'(regs[w[25:21]]);
        b   = int'(regs[w[20:16]]);
        off = int'(w[15:0]);
        if (off >= 32768) off -= 65536;
        np = (p + 1) & PC_MASK; ret = 1; ill = 0; hlt = 0; tk = 0;
        if (op <= 11) begin
        end else if (op >= 14 && op <= 19) begin
            case (op)
                14: tk = (a == b);
                15: tk = (a != b);
                16: tk = (a > b);
                17: tk = (a >= b);
                18: tk = (a < b);
                default: tk = (a <= b);
            endcase
            if (tk) np = (p + 1 + off) & PC_MASK;
        end else if (op == 20) begin
            np = int'(w) & PC_MASK;
        end else if (op == 63) begin
            np = p; hlt = 1;
`ifdef SEQ_JAL_EN
        end else if (op == 21) begin
            np = a & PC_MASK;
        end else if (op == 22) begin
            np = int'(w) & PC_MASK;
`endif
        end else begin
            ret = 0; ill = 1;
        end
    endtask

    task automatic compare_now();
        bit ev, elw;
        int op;
        if (!m_known) return;
        op  = int'(m_word[31:26]);
        ev  = m_run && (m_cyc >= 2) && (op <= 11);
`ifdef SEQ_JAL_EN
        elw = m_run && (m_cyc >= 2) && (op == 22);
`else
        elw = 0;
`endif
        chk("busy", busy, m_run);
        chk("halted", halted, m_halted);
        chk("pc", pc, 32'(m_pc));
        chk("retired", retired, 32'(m_ret));
        chk("illegal", illegal, m_ill);
        chk("exe_valid", exe_valid, ev);
        if (ev) chk("exe_instr", exe_instr, m_word);
        chk("link_we", link_we, elw);
        if (elw) chk("link_data", link_data, 32'((m_pc + 1) & PC_MASK));
        if (m_run && m_cyc == 0) chk("imem_addr", imem_addr, 32'(m_pc));
    endtask

    task automatic model_edge(input bit s, input bit r, input bit rst);
        int np;
        bit ret, ill, hlt;
        if (rst) begin
            m_known = 1; m_run = 0; m_halted = 0; m_pc = int'(START_PC);
            m_ret = 0; m_ill = 0; m_cyc = 0; m_word = '0;
        end else if (!m_known) begin
        end else if (!m_run) begin
            if (s) begin
                m_run = 1; m_halted = 0; m_cyc = 0; m_pc = int'(START_PC); m_ill = 0;
            end
        end else if (m_cyc == 0) begin
            m_word = imem[m_pc];
            m_cyc  = 1;
        end else if (m_cyc == 1) begin
            m_cyc = 2;
        end else if (int'(m_word[31:26]) <= 11 && !r) begin
            m_cyc++;
        end else begin
            isa_exec(m_word, m_pc, np, ret, ill, hlt);
            m_pc = np;
            if (ret && m_ret < RET_MAX) m_ret++;
            if (ill) m_ill = 1;
            m_cyc = 0;
            if (hlt) begin m_run = 0; m_halted = 1; end
        end
    endtask

    // Called at a falling edge: check, drive, advance model, wait one cycle.
    task automatic step(input bit s, input bit r, input bit rst);
        compare_now();
        start = s; exe_ready = r; reset = rst;
        model_edge(s, r, rst);
        @(negedge clk);
    endtask

    task automatic run_n(input int n, input bit r);
        for (int i = 0; i < n; i++) step(0, r, 0);
    endtask

    function automatic logic [31:0] rand_word();
        int k, j;
        logic [31:0] w;
        k = $urandom_range(0, 99);
        w = $urandom;
        if (k < 40) w[31:26] = 6'($urandom_range(0, 11));
        else if (k < 65) begin
            w[31:26] = 6'($urandom_range(14, 19));
            w[15:0]  = 16'($urandom_range(0, 16) - 8);
        end else if (k < 72) w[31:26] = 6'd20;
        else if (k < 80) w[31:26] = 6'($urandom_range(21, 22));
        else if (k < 92) begin
            j = $urandom_range(0, 41);
            w[31:26] = (j == 0) ? 6'd12 : (j == 1) ? 6'd13 : 6'(j + 21);
        end else w[31:26] = 6'd63;
        return w;
    endfunction

    function automatic logic [31:0] rand_reg();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7;
            3: return 32'hFFFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; exe_ready = 1'b0;
        for (int i = 0; i < 512; i++) imem[i] = HALT;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        @(negedge clk);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", exe_valid, 0);
        chk("rst_retired", retired, 0);
        chk("link_addr", link_addr, 31);

        // add r3=r1+r2 with ready high
        imem[0] = 32'h0022_1800;
        step(1, 1, 0);
        run_n(2, 1);
        chk("t1_valid", exe_valid, 1);
        chk("t1_instr", exe_instr, 32'h0022_1800);
        chk("t1_pc0", pc, 0);
        step(0, 1, 0);
        chk("t1_pc1", pc, 1);
        chk("t1_ret", retired, 1);
        chk("t1_model_ret", 32'(m_ret), 1);
        run_n(3, 1);
        chk("t1_halted", halted, 1);
        chk("t1_ret2", retired, 2);

        // ALU op stalled four cycles
        imem[0] = 32'h0422_1800;
        step(1, 0, 0);
        run_n(2, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            chk("t2_hold_valid", exe_valid, 1);
            chk("t2_hold_instr", exe_instr, 32'h0422_1800);
            chk("t2_hold_pc", pc, 0);
        end
        step(0, 1, 0);
        chk("t2_pc", pc, 1);
        run_n(3, 1);
        chk("t2_ret", retired, 4);

        // beq taken backwards
        regs[1] = 32'd7; regs[2] = 32'd7;
        imem[0] = 32'h5000_0005;
        imem[5] = 32'h3822_FFFD;
        step(1, 1, 0);
        run_n(3, 1);
        chk("t3_j_pc", pc, 5);
        run_n(3, 1);
        chk("t3_beq_pc", pc, 3);
        chk("t3_model_pc", 32'(m_pc), 3);
        run_n(3, 1);
        chk("t3_halted", halted, 1);

        // bgt signed not taken
        regs[3] = 32'hFFFF_FFFF; regs[4] = 32'd1;
        imem[5] = 32'h4064_0010;
        step(1, 1, 0);
        run_n(6, 1);
        chk("t4_bgt_pc", pc, 6);
        chk("t4_model_pc", 32'(m_pc), 6);
        run_n(3, 1);

        // pc wrap through a not-taken branch and a jump at 511
        imem[0]   = 32'h5000_01FF;
        imem[511] = 32'h3C22_0000;
        step(1, 1, 0);
        run_n(3, 1);
        chk("t5_pc511", pc, 511);
        run_n(3, 1);
        chk("t5_br_wrap", pc, 0);
        step(0, 0, 1);
        imem[511] = 32'h5000_0000;
        step(1, 1, 0);
        run_n(6, 1);
        chk("t5_j_wrap", pc, 0);
        step(0, 0, 1);

        // illegal opcode, halt, restart
        imem[0] = 32'h3000_0000;
        imem[1] = HALT;
        step(1, 1, 0);
        run_n(3, 1);
        chk("t6_illegal", illegal, 1);
        chk("t6_pc", pc, 1);
        chk("t6_ret", retired, 0);
        run_n(3, 1);
        chk("t6_halted", halted, 1);
        step(1, 1, 0);
        chk("t6_re_pc", pc, 0);
        chk("t6_re_ill", illegal, 0);
        chk("t6_re_ret", retired, 1);
        step(0, 0, 1);

        // jal / jr
        regs[5] = 32'd11;
        imem[0]  = 32'h5000_000A;
        imem[10] = 32'h5800_0028;
        imem[40] = 32'h54A0_0000;
        imem[11] = HALT;
        step(1, 1, 0);
        run_n(3, 1);
        chk("t7_pc10", pc, 10);
        run_n(2, 1);
`ifdef SEQ_JAL_EN
        chk("t7_link_we", link_we, 1);
        chk("t7_link_data", link_data, 11);
        step(0, 1, 0);
        chk("t7_jal_pc", pc, 40);
        chk("t7_link_off", link_we, 0);
        run_n(3, 1);
        chk("t7_jr_pc", pc, 11);
`else
        chk("t7_link_we", link_we, 0);
        step(0, 1, 0);
        chk("t7_jal_ill", illegal, 1);
        chk("t7_jal_pc", pc, 11);
`endif
        run_n(3, 1);
        chk("t7_halted", halted, 1);

        // reset while an ALU op waits for ready
        imem[0] = 32'h3400_0000;
        imem[1] = 32'h0C00_0000;
        step(1, 0, 0);
        run_n(3, 0);
        run_n(4, 0);
        chk("t8_wait_valid", exe_valid, 1);
        chk("t8_wait_ill", illegal, 1);
        step(0, 0, 1);
        chk("t8_valid", exe_valid, 0);
        chk("t8_link_we", link_we, 0);
        chk("t8_busy", busy, 0);
        chk("t8_halted", halted, 0);
        chk("t8_illegal", illegal, 0);
        chk("t8_retired", retired, 0);
        chk("t8_instr", exe_instr, 0);
        chk("t8_imem_addr", imem_addr, 0);
        chk("t8_link_data", link_data, 0);
        chk("t8_pc", pc, 0);

        // randomized programs
        for (int i = 0; i < 32; i++) regs[i] = rand_reg();
        for (int i = 0; i < 512; i++) imem[i] = rand_word();
        step(0, 0, 1);
        for (int c = 0; c < 20000; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 999) == 0);
            if (c % 4000 == 3999)
                for (int i = 0; i < 512; i++)
                    if (!m_run) imem[i] = rand_word();
        end
        compare_now();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
